// File: rtl/pong_defs.sv
// Shared definitions for the pong score/display block: FSM encoding,
// seven-segment glyphs, digit slot numbering and the debug view.
package pong_defs;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_t;

  // Active-low cathodes, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] BCD_NINE = 4'd9;

  localparam int unsigned REFRESH_DIV_DEFAULT = 25000;
  localparam int unsigned BLINK_DIV_DEFAULT   = 12500000;

  // Digit slot = anode bit; the sweep starts at the leftmost digit.
  localparam logic [1:0] IDX_LEFT_TENS  = 2'd3;
  localparam logic [1:0] IDX_LEFT_ONES  = 2'd2;
  localparam logic [1:0] IDX_RIGHT_TENS = 2'd1;
  localparam logic [1:0] IDX_RIGHT_ONES = 2'd0;
  localparam logic [1:0] IDX_START      = IDX_LEFT_TENS;

  // Debug view: FSM state, both BCD scores, and a one-cycle strobe that is
  // high in the first cycle showing the result of an accepted event.
  typedef struct packed {
    state_t     state;
    logic [3:0] left_tens;
    logic [3:0] left_ones;
    logic [3:0] right_tens;
    logic [3:0] right_ones;
    logic       evt;
  } dbg_t;

  function automatic logic [6:0] seg_glyph(input logic [3:0] digit);
    logic [6:0] glyph;
    case (digit)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_BLANK;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/score_display_if.sv
// Link between the game core / board and the score display block.
// No valid/ready here: goal_left, goal_right and new_game are levels whose
// rising edges are events; there is no backpressure, every edge is sampled.
interface score_display_if;
  import pong_defs::*;

  logic       goal_left;
  logic       goal_right;
  logic       new_game;
  logic       game_over;
  logic       winner;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  dbg_t       dbg;

  modport master (
    output goal_left, goal_right, new_game,
    input  game_over, winner, seg, an, dp, dbg
  );

  modport slave (
    input  goal_left, goal_right, new_game,
    output game_over, winner, seg, an, dp, dbg
  );

endinterface

// File: rtl/bcd_counter2.sv
// Two-digit BCD score counter with clear, increment and a flag telling
// whether the next increment lands exactly on WIN_SCORE.
module bcd_counter2
  import pong_defs::*;
#(
  parameter int unsigned WIN_SCORE = 11
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       will_win
);

  logic [6:0] value;

  assign value    = ({3'b000, tens} * 7'd10) + {3'b000, ones};
  assign will_win = ((value + 7'd1) == 7'(WIN_SCORE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (clr) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc) begin
      if (ones == BCD_NINE) begin
        ones <= 4'd0;
        tens <= (tens == BCD_NINE) ? 4'd0 : tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/score_display.sv
// Pong score keeper: counts goal events in BCD, detects the match winner and
// multiplexes both scores onto a 4-digit active-low seven-segment display.
module score_display
  import pong_defs::*;
#(
  parameter int unsigned WIN_SCORE   = 11,
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT,
  parameter int unsigned BLINK_DIV   = BLINK_DIV_DEFAULT
) (
  input logic            clk,
  input logic            reset_n,
  score_display_if.slave bus
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  // Edge detectors reset high so a level already asserted at release is ignored.
  logic gl_cur, gl_prev, gr_cur, gr_prev, ng_cur, ng_prev;
  logic left_evt, right_evt, new_evt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gl_cur  <= 1'b1;
      gl_prev <= 1'b1;
      gr_cur  <= 1'b1;
      gr_prev <= 1'b1;
      ng_cur  <= 1'b1;
      ng_prev <= 1'b1;
    end else begin
      gl_cur  <= bus.goal_left;
      gl_prev <= gl_cur;
      gr_cur  <= bus.goal_right;
      gr_prev <= gr_cur;
      ng_cur  <= bus.new_game;
      ng_prev <= ng_cur;
    end
  end

  assign left_evt  = gl_cur & ~gl_prev;
  assign right_evt = gr_cur & ~gr_prev;
  assign new_evt   = ng_cur & ~ng_prev;

  logic       clr, inc_left, inc_right;
  logic [3:0] left_tens, left_ones, right_tens, right_ones;
  logic       left_win, right_win;

  bcd_counter2 #(.WIN_SCORE(WIN_SCORE)) u_left (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (clr),
    .inc      (inc_left),
    .tens     (left_tens),
    .ones     (left_ones),
    .will_win (left_win)
  );

  bcd_counter2 #(.WIN_SCORE(WIN_SCORE)) u_right (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (clr),
    .inc      (inc_right),
    .tens     (right_tens),
    .ones     (right_ones),
    .will_win (right_win)
  );

  state_t state, state_next;
  logic   winner_q, winner_next;
  logic   accept, evt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= PLAY;
      winner_q <= 1'b0;
      evt_q    <= 1'b0;
    end else begin
      state    <= state_next;
      winner_q <= winner_next;
      evt_q    <= accept;
    end
  end

  // new_game outranks goals; simultaneous goals are ambiguous and dropped.
  always_comb begin
    state_next  = state;
    winner_next = winner_q;
    clr         = 1'b0;
    inc_left    = 1'b0;
    inc_right   = 1'b0;
    accept      = 1'b0;
    if (new_evt) begin
      clr        = 1'b1;
      accept     = 1'b1;
      state_next = PLAY;
    end else if ((state == PLAY) && (left_evt ^ right_evt)) begin
      accept    = 1'b1;
      inc_left  = left_evt;
      inc_right = right_evt;
      if (left_evt && left_win) begin
        state_next  = OVER;
        winner_next = 1'b0;
      end
      if (right_evt && right_win) begin
        state_next  = OVER;
        winner_next = 1'b1;
      end
    end
  end

  assign bus.game_over = (state == OVER);
  assign bus.winner    = winner_q;

  logic [RW-1:0] refresh_cnt;
  logic [1:0]    idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh_cnt <= '0;
      idx         <= IDX_START;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      idx         <= idx - 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  // Blink phase restarts shown (1) every time OVER is entered.
  logic [BW-1:0] blink_cnt;
  logic          phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (state == PLAY) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  logic [3:0] digit;
  logic       blank_lz, winner_digit, hide;
  logic [6:0] seg_next;

  always_comb begin
    digit    = left_ones;
    blank_lz = 1'b0;
    case (idx)
      IDX_LEFT_TENS: begin
        digit    = left_tens;
        blank_lz = (left_tens == 4'd0);
      end
      IDX_LEFT_ONES:  digit = left_ones;
      IDX_RIGHT_TENS: begin
        digit    = right_tens;
        blank_lz = (right_tens == 4'd0);
      end
      IDX_RIGHT_ONES: digit = right_ones;
      default:        digit = left_ones;
    endcase
    // Right player's digits occupy slots 1..0, i.e. idx[1] == 0.
    winner_digit = (winner_q == ~idx[1]);
    hide         = (state == OVER) && !phase && winner_digit;
    seg_next     = (blank_lz || hide) ? SEG_BLANK : seg_glyph(digit);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.an  <= 4'b1111;
      bus.seg <= SEG_BLANK;
      bus.dp  <= 1'b1;
    end else begin
      bus.an  <= ~(4'b0001 << idx);
      bus.seg <= seg_next;
      bus.dp  <= (idx != IDX_LEFT_ONES);
    end
  end

  assign bus.dbg = '{state:      state,
                     left_tens:  left_tens,
                     left_ones:  left_ones,
                     right_tens: right_tens,
                     right_ones: right_ones,
                     evt:        evt_q};

endmodule

// File: tb/tb_score_display.sv
// Randomised scoreboard bench for score_display with a behavioural score model
// and directed display sweep, blink and reset checks.
module tb_score_display;
  import pong_defs::*;

  localparam int WIN  = 11;
  localparam int RDIV = 4;
  localparam int BDIV = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  score_display_if bus();

  score_display #(
    .WIN_SCORE   (WIN),
    .REFRESH_DIV (RDIV),
    .BLINK_DIV   (BDIV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---------------- reference model and scoreboard ----------------
  // Expected entry: {game_over, winner, left[6:0], right[6:0]}.
  logic [15:0] exp_q[$];
  int m_left = 0, m_right = 0;
  bit m_over = 1'b0, m_win = 1'b0;
  int total = 0, bad = 0;

  logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [6:0] BLANK = 7'h7F;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int left_val();
    return int'(bus.dbg.left_tens) * 10 + int'(bus.dbg.left_ones);
  endfunction

  function automatic int right_val();
    return int'(bus.dbg.right_tens) * 10 + int'(bus.dbg.right_ones);
  endfunction

  task automatic model_apply(input bit gl, input bit gr, input bit ng);
    if (ng) begin
      m_left  = 0;
      m_right = 0;
      m_over  = 1'b0;
    end else if (!m_over && (gl != gr)) begin
      if (gl) m_left++;
      else    m_right++;
      if (m_left == WIN)  begin m_over = 1'b1; m_win = 1'b0; end
      if (m_right == WIN) begin m_over = 1'b1; m_win = 1'b1; end
    end else begin
      return;
    end
    exp_q.push_back({m_over, m_over ? m_win : 1'b0, 7'(m_left), 7'(m_right)});
  endtask

  // ---------------- driver ----------------
  task automatic pulse(input bit gl, input bit gr, input bit ng);
    model_apply(gl, gr, ng);
    @(negedge clk);
    bus.goal_left  = gl;
    bus.goal_right = gr;
    bus.new_game   = ng;
    repeat (2) @(negedge clk);
    bus.goal_left  = 1'b0;
    bus.goal_right = 1'b0;
    bus.new_game   = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulses(input bit gl, input bit gr, input int n);
    for (int i = 0; i < n; i++) pulse(gl, gr, 1'b0);
  endtask

  task automatic wait_an(input logic [3:0] target, input string name);
    int budget = 200;
    while (bus.an !== target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check(name, int'(bus.an), int'(target));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n && bus.dbg.evt) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 1, 0);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("score_left",  left_val(),  int'(e[13:7]));
        check("score_right", right_val(), int'(e[6:0]));
        check("game_over",   int'(bus.game_over), int'(e[15]));
        check("state",       int'(bus.dbg.state), int'(e[15]));
        if (e[15]) check("winner", int'(bus.winner), int'(e[14]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] sweep_an  [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [6:0] sweep_seg [4];
    logic       sweep_dp  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int loser_bad, winner_bad;

    bus.goal_left  = 1'b1;
    bus.goal_right = 1'b0;
    bus.new_game   = 1'b0;
    repeat (3) @(negedge clk);

    check("reset_an",        int'(bus.an), 4'hF);
    check("reset_seg",       int'(bus.seg), 7'h7F);
    check("reset_dp",        int'(bus.dp), 1);
    check("reset_game_over", int'(bus.game_over), 0);
    check("reset_winner",    int'(bus.winner), 0);
    check("reset_left",      left_val(), 0);
    check("reset_right",     right_val(), 0);

    // Goal level already high at release must not count.
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("hold_at_release", left_val(), 0);
    bus.goal_left = 1'b0;
    repeat (3) @(negedge clk);

    pulses(1'b1, 1'b0, 3);
    check("left_after_3", left_val(), 3);
    check("over_after_3", int'(bus.game_over), 0);

    pulses(1'b0, 1'b1, 10);
    pulses(1'b0, 1'b1, 1);
    check("right_win_score", right_val(), WIN);
    check("right_win_over",  int'(bus.game_over), 1);
    check("right_win_who",   int'(bus.winner), 1);
    pulses(1'b1, 1'b0, 1);
    check("left_frozen", left_val(), 3);

    // Loser digit must stay lit; winner digits show '1' or blank while blinking.
    loser_bad  = 0;
    winner_bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.an == 4'b1011 && bus.seg != glyph[3]) loser_bad++;
      if ((bus.an == 4'b1101 || bus.an == 4'b1110) &&
          bus.seg != glyph[1] && bus.seg != BLANK) winner_bad++;
    end
    check("over_loser_shown",   loser_bad, 0);
    check("over_winner_glyphs", winner_bad, 0);

    pulse(1'b1, 1'b0, 1'b1);
    check("newgame_beats_goal_left", left_val(), 0);
    check("newgame_state",           int'(bus.dbg.state), int'(PLAY));

    pulses(1'b1, 1'b0, 1);
    pulses(1'b1, 1'b1, 1);
    check("both_left",  left_val(), 1);
    check("both_right", right_val(), 0);

    // Left 09 -> 10 carry, right 05; then a full refresh sweep.
    pulse(1'b0, 1'b0, 1'b1);
    pulses(1'b1, 1'b0, 9);
    check("left_nine", left_val(), 9);
    pulses(1'b1, 1'b0, 1);
    check("left_tens", int'(bus.dbg.left_tens), 1);
    check("left_ones", int'(bus.dbg.left_ones), 0);
    pulses(1'b0, 1'b1, 5);
    sweep_seg = '{glyph[1], glyph[0], BLANK, glyph[5]};
    wait_an(4'b0111, "sweep_start_timeout");
    for (int k = 0; k < 4; k++) begin
      check($sformatf("sweep_an_%0d", k),  int'(bus.an),  int'(sweep_an[k]));
      check($sformatf("sweep_seg_%0d", k), int'(bus.seg), int'(sweep_seg[k]));
      check($sformatf("sweep_dp_%0d", k),  int'(bus.dp),  int'(sweep_dp[k]));
      repeat (RDIV) @(negedge clk);
    end

    // Asynchronous reset in the middle of a sweep.
    wait_an(4'b1101, "midsweep_timeout");
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_an",   int'(bus.an), 4'hF);
    check("async_reset_seg",  int'(bus.seg), 7'h7F);
    check("async_reset_left", left_val(), 0);
    check("async_reset_over", int'(bus.game_over), 0);
    m_left = 0; m_right = 0; m_over = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Randomised play against the model.
    for (int i = 0; i < 200; i++) begin
      int kind;
      kind = $urandom_range(0, 11);
      if (kind < 5)       pulse(1'b1, 1'b0, 1'b0);
      else if (kind < 10) pulse(1'b0, 1'b1, 1'b0);
      else if (kind == 10) pulse(1'b1, 1'b1, 1'b0);
      else if ($urandom_range(0, 3) == 0) pulse(1'(i & 1), 1'(~i & 1), 1'b1);
      else pulses(1'b1, 1'b1, 1);
      if (i % 50 == 49) pulse(1'b0, 1'b0, 1'b1);
    end
    repeat (10) @(negedge clk);
    check("final_left",  left_val(), m_left);
    check("final_right", right_val(), m_right);
    check("final_over",  int'(bus.game_over), int'(m_over));
    check("queue_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
